// File: rtl/cache_pkg.sv
// Shared types and default widths for the cache request arbiter and its timer.
package cache_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_WORD_SIZE  = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } arb_state_t;

    typedef logic req_id_t;

endpackage

// File: rtl/cache_arb_timer.sv
// WAIT-state cycle counter; expired flags the last permitted WAIT cycle.
module cache_arb_timer #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] r_count;

    // NOTE: sequential state is written with <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count <= '0;
        end else if (clear) begin
            r_count <= '0;
        end else if (enable && !expired) begin
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign expired = (r_count == LAST);

endmodule

// File: rtl/cache_req_arbiter.sv
// Two-requester round-robin front end to a single-outstanding cache controller,
// with a WAIT timeout that returns an error completion.
module cache_req_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int WORD_SIZE      = DEF_WORD_SIZE,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req0_valid,
    input  logic                  req0_type,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [WORD_SIZE-1:0]  req0_wdata,
    output logic                  req0_ready,
    output logic                  req0_done,
    output logic [WORD_SIZE-1:0]  req0_rdata,
    output logic                  req0_err,
    input  logic                  req1_valid,
    input  logic                  req1_type,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [WORD_SIZE-1:0]  req1_wdata,
    output logic                  req1_ready,
    output logic                  req1_done,
    output logic [WORD_SIZE-1:0]  req1_rdata,
    output logic                  req1_err,
    output logic                  cache_req_valid,
    output logic                  cache_req_type,
    output logic [ADDR_WIDTH-1:0] cache_addr,
    output logic [WORD_SIZE-1:0]  cache_wdata,
    input  logic                  cache_done,
    input  logic [WORD_SIZE-1:0]  cache_rdata,
    output logic                  busy,
    output logic                  grant_id
);

    arb_state_t            r_state;
    req_id_t               r_last;
    req_id_t               r_grant;
    logic                  r_type;
    logic                  r_err;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [WORD_SIZE-1:0]  r_wdata;

    req_id_t               w_winner;
    logic                  w_accept;
    logic                  w_expired;
    logic                  w_resp;
    logic [WORD_SIZE-1:0]  w_rdata;

    // NOTE: the default assignment first keeps this block free of inferred latches.
    always_comb begin
        w_winner = 1'b0;
        if (req0_valid && req1_valid) begin
            w_winner = ~r_last;
        end else if (req1_valid) begin
            w_winner = 1'b1;
        end
    end

    // Ready is gated by rst so nothing looks accepted while reset is held.
    assign w_accept   = rst && (r_state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = w_accept && (w_winner == 1'b0);
    assign req1_ready = w_accept && (w_winner == 1'b1);

    cache_arb_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clear  (r_state != WAIT),
        .enable (r_state == WAIT),
        .expired(w_expired)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
            r_last  <= 1'b1;
            r_grant <= 1'b0;
            r_type  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant <= w_winner;
                        r_last  <= w_winner;
                        r_type  <= w_winner ? req1_type  : req0_type;
                        r_addr  <= w_winner ? req1_addr  : req0_addr;
                        r_wdata <= w_winner ? req1_wdata : req0_wdata;
                        r_err   <= 1'b0;
                        r_state <= ISSUE;
                    end
                end
                ISSUE: r_state <= WAIT;
                WAIT: begin
                    // A completion in the final WAIT cycle still counts as success.
                    if (cache_done) begin
                        r_err   <= 1'b0;
                        r_state <= RESP;
                    end else if (w_expired) begin
                        r_err   <= 1'b1;
                        r_state <= RESP;
                    end
                end
                RESP:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // cache_rdata arrives one cycle after cache_done, i.e. exactly in RESP.
    assign w_resp  = (r_state == RESP);
    assign w_rdata = (!r_type && !r_err) ? cache_rdata : '0;

    assign req0_done  = w_resp && (r_grant == 1'b0);
    assign req1_done  = w_resp && (r_grant == 1'b1);
    assign req0_err   = req0_done && r_err;
    assign req1_err   = req1_done && r_err;
    assign req0_rdata = req0_done ? w_rdata : '0;
    assign req1_rdata = req1_done ? w_rdata : '0;

    assign cache_req_valid = (r_state == ISSUE);
    assign cache_req_type  = r_type;
    assign cache_addr      = r_addr;
    assign cache_wdata     = r_wdata;
    assign busy            = (r_state != IDLE);
    assign grant_id        = r_grant;

endmodule

// File: doc/cache_req_arbiter.md
CACHE_REQ_ARBITER -- requirements
Module: cache_req_arbiter

Interface
REQ-001 Parameters SHALL be, one per line:
  ADDR_WIDTH, 32, request address width.
  WORD_SIZE, 32, data word width.
  TIMEOUT_CYCLES, 64, maximum WAIT cycles before an error response (at least 2).
REQ-002 Ports SHALL be, one per line:
  clk  in  1  single clock; all state updates on the rising edge.
  rst  in  1  asynchronous, active-low reset.
  reqN_valid  in  1  requester N (N=0,1) has a request pending.
  reqN_type  in  1  0=read, 1=write.
  reqN_addr  in  ADDR_WIDTH  request address.
  reqN_wdata  in  WORD_SIZE  write data.
  reqN_ready  out  1  request accepted this cycle.
  reqN_done  out  1  one-cycle completion pulse.
  reqN_rdata  out  WORD_SIZE  read data, valid while reqN_done=1.
  reqN_err  out  1  timeout flag, valid while reqN_done=1.
  cache_req_valid  out  1  request strobe to the cache controller.
  cache_req_type  out  1  forwarded type.
  cache_addr  out  ADDR_WIDTH  forwarded address.
  cache_wdata  out  WORD_SIZE  forwarded write data.
  cache_done  in  1  completion pulse from the cache controller.
  cache_rdata  in  WORD_SIZE  cache read word, registered one cycle after cache_done.
  busy  out  1  high in every state except IDLE.
  grant_id  out  1  index of the requester currently owning the cache.

Function
REQ-003 The FSM SHALL have states IDLE, ISSUE, WAIT, RESP; reset state SHALL be IDLE.
REQ-004 IDLE: with at least one reqN_valid, the block SHALL grant the requester selected by REQ-005, assert that requester's reqN_ready combinationally, capture type/addr/wdata and grant_id on the edge, and go to ISSUE.
REQ-005 Arbitration SHALL be round-robin: if both are valid, the requester not served last wins; a single valid requester always wins; the pointer SHALL update only on acceptance.
REQ-006 ISSUE SHALL last exactly one cycle with cache_req_valid=1, then go to WAIT.
REQ-007 cache_req_type, cache_addr and cache_wdata SHALL come from the capture registers and stay stable from ISSUE through RESP.
REQ-008 WAIT SHALL hold cache_req_valid=0 and move to RESP on the cycle after cache_done=1.
REQ-009 WAIT SHALL count cycles from 0; on reaching TIMEOUT_CYCLES-1 without cache_done, it SHALL go to RESP with the error flag set.
REQ-010 RESP SHALL last one cycle. It SHALL assert reqN_done for grant_id only. reqN_rdata SHALL equal cache_rdata for a successful read, or 0 for a write or a timeout. reqN_err SHALL be 1 only on timeout. The next state SHALL be IDLE.
REQ-011 Hit latency SHALL be: accept at edge T, ISSUE in cycle T+1, cache_done in cycle T+2, reqN_done in cycle T+3.
REQ-012 A cache_done outside WAIT SHALL be ignored.
REQ-013 Changes to reqN_valid or request fields after acceptance SHALL have no effect.
REQ-014 A requester dropping valid before ready SHALL lose nothing: no state change.
REQ-015 The non-granted reqN_ready, and every reqN_done and reqN_err, SHALL be 0 outside the cases above.

Reset
REQ-016 rst=0 SHALL immediately force state IDLE, round-robin pointer to favour requester 0, timer 0, capture registers 0, and all outputs 0, including mid-transaction.
REQ-017 After rst rises, the first accept SHALL occur no earlier than the first rising clk edge.

Structure
REQ-018 Shared package cache_pkg SHALL hold the ADDR_WIDTH and WORD_SIZE defaults, typedef arb_state_t (IDLE, ISSUE, WAIT, RESP) and typedef req_id_t (1 bit).
REQ-019 The WAIT timeout counter SHALL be the sub-module cache_arb_timer, with clear, enable and expired ports, width $clog2(TIMEOUT_CYCLES).
REQ-020 All other logic SHALL live in one module, with no other sub-modules.

Verification
REQ-021 Read hit: req0 read addr 0x0000_0040, cache_done two cycles after ready, cache_rdata=0xDEAD_BEEF -> req0_done in cycle T+3, req0_rdata=0xDEAD_BEEF, req0_err=0.
REQ-022 Contention: req0 and req1 valid in the same cycle after reset -> req0 granted first, req1 granted in the next IDLE; the next simultaneous pair -> req0 granted first again, since req1 was served last.
REQ-023 Timeout: req1 write, cache_done never asserted -> req1_done exactly TIMEOUT_CYCLES cycles after entering WAIT, req1_err=1, req1_rdata=0.
REQ-024 Stability: req0 write addr 0x0000_0084 data 0x1234_5678, changed to 0xFFFF_FFFF after accept -> cache_addr/cache_wdata stay 0x0000_0084/0x1234_5678 until RESP.
REQ-025 Reset mid-WAIT: rst=0 during WAIT -> busy=0, all outputs 0 immediately; a stale cache_done after release -> no reqN_done.
